pe_controller: RTL and testbench

//   Sequencing FSM for one PE convolution datapath. Loads stride/filter-size config,

---
 rtl/pe_controller.sv | 194 +++++++++++++++++++
 tb/tb_pe_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_controller.sv
// pe_controller: sequencing FSM for one PE convolution datapath.
// Loads stride/filter-size config, issues MAC beats while the operands are
// available, marks window starts/ends, steps rows and filters, drains the
// MAC/accumulate pipeline and then pulses done.
module pe_controller #(
    parameter int ROW_CNT_WIDTH  = 8,
    parameter int FILT_CNT_WIDTH = 8,
    parameter int DRAIN_CYCLES   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROW_CNT_WIDTH-1:0]  num_rows,
    input  logic [FILT_CNT_WIDTH-1:0] num_filters,
    input  logic                      av_data,
    input  logic                      av_filter,
    input  logic                      co_filter,
    input  logic                      end_of_row,
    output logic                      ld_stride,
    output logic                      ld_filterSize,
    output logic                      put_data,
    output logic                      put_filter,
    output logic                      clear_sum,
    output logic                      store_buffer,
    output logic                      next_row,
    output logic                      next_filter,
    output logic                      busy,
    output logic                      done
);

    // Drain counter holds DRAIN_CYCLES-1 down to 0.
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONFIG = 3'd1,
        S_MAC    = 3'd2,
        S_STORE  = 3'd3,
        S_ADV    = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                    state_r;
    logic [ROW_CNT_WIDTH-1:0]  num_rows_r;
    logic [FILT_CNT_WIDTH-1:0] num_filters_r;
    logic [ROW_CNT_WIDTH-1:0]  row_cnt_r;
    logic [FILT_CNT_WIDTH-1:0] filt_cnt_r;
    logic [DRAIN_W-1:0]        drain_cnt_r;
    logic                      first_r;
    logic                      eor_r;

    logic beat_s;
    logic last_row_s;
    logic last_filt_s;
    logic zero_job_s;

    // A beat only happens in MAC when both operands are present.
    assign beat_s      = (state_r == S_MAC) && av_data && av_filter;
    // Latched counts are known non-zero once past CONFIG, so the -1 never underflows there.
    assign last_row_s  = (row_cnt_r == (num_rows_r - ROW_CNT_WIDTH'(1)));
    assign last_filt_s = (filt_cnt_r == (num_filters_r - FILT_CNT_WIDTH'(1)));
    assign zero_job_s  = (num_rows_r == ROW_CNT_WIDTH'(0)) ||
                         (num_filters_r == FILT_CNT_WIDTH'(0));

    // State register, job configuration latch and loop/drain counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            num_rows_r    <= '0;
            num_filters_r <= '0;
            row_cnt_r     <= '0;
            filt_cnt_r    <= '0;
            drain_cnt_r   <= '0;
            first_r       <= 1'b1;
            eor_r         <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        num_rows_r    <= num_rows;
                        num_filters_r <= num_filters;
                        state_r       <= S_CONFIG;
                    end else begin
                        state_r       <= S_IDLE;
                    end
                end
                S_CONFIG: begin
                    row_cnt_r  <= '0;
                    filt_cnt_r <= '0;
                    first_r    <= 1'b1;
                    if (zero_job_s) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (beat_s) begin
                        first_r <= 1'b0;
                        if (co_filter) begin
                            eor_r   <= end_of_row;
                            state_r <= S_STORE;
                        end else begin
                            state_r <= S_MAC;
                        end
                    end else begin
                        state_r <= S_MAC;
                    end
                end
                S_STORE: begin
                    first_r <= 1'b1;
                    if (eor_r) begin
                        state_r <= S_ADV;
                    end else begin
                        state_r <= S_MAC;
                    end
                end
                S_ADV: begin
                    if (!last_row_s) begin
                        row_cnt_r <= row_cnt_r + ROW_CNT_WIDTH'(1);
                        state_r   <= S_MAC;
                    end else begin
                        row_cnt_r  <= '0;
                        filt_cnt_r <= filt_cnt_r + FILT_CNT_WIDTH'(1);
                        if (last_filt_s) begin
                            drain_cnt_r <= DRAIN_W'(DRAIN_CYCLES - 1);
                            state_r     <= S_DRAIN;
                        end else begin
                            state_r     <= S_MAC;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == DRAIN_W'(0)) begin
                        state_r <= S_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
                        state_r     <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // State-decoded outputs; beat-related outputs also qualified by operand availability.
    always_comb begin
        ld_stride     = 1'b0;
        ld_filterSize = 1'b0;
        put_data      = 1'b0;
        put_filter    = 1'b0;
        clear_sum     = 1'b0;
        store_buffer  = 1'b0;
        next_row      = 1'b0;
        next_filter   = 1'b0;
        busy          = (state_r != S_IDLE);
        done          = 1'b0;
        case (state_r)
            S_CONFIG: begin
                ld_stride     = 1'b1;
                ld_filterSize = 1'b1;
            end
            S_MAC: begin
                put_data   = beat_s;
                put_filter = beat_s;
                clear_sum  = beat_s && first_r;
            end
            S_STORE: begin
                store_buffer = 1'b1;
            end
            S_ADV: begin
                next_row = 1'b1;
                if (last_row_s) begin
                    next_filter = 1'b1;
                end else begin
                    next_filter = 1'b0;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                ld_stride = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_controller.sv
// Directed testbench for pe_controller. A small datapath model supplies
// co_filter/end_of_row from the bench's own window/beat counters; per-cycle
// observations are tallied and compared against hand-derived expectations.
module tb_pe_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_rows = 8'd0;
    logic [7:0] num_filters = 8'd0;
    logic       av_data = 1'b0;
    logic       av_filter = 1'b0;
    logic       co_filter = 1'b0;
    logic       end_of_row = 1'b0;
    logic       ld_stride, ld_filterSize, put_data, put_filter, clear_sum;
    logic       store_buffer, next_row, next_filter, busy, done;

    pe_controller #(.ROW_CNT_WIDTH(8), .FILT_CNT_WIDTH(8), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_rows(num_rows), .num_filters(num_filters),
        .av_data(av_data), .av_filter(av_filter),
        .co_filter(co_filter), .end_of_row(end_of_row),
        .ld_stride(ld_stride), .ld_filterSize(ld_filterSize),
        .put_data(put_data), .put_filter(put_filter), .clear_sum(clear_sum),
        .store_buffer(store_buffer), .next_row(next_row), .next_filter(next_filter),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // datapath model
    int win_len = 1;
    int wins_per_row = 1;
    int beat_idx = 0;
    int win_idx = 0;

    // per-job observations
    int cyc = 0;
    int c_put, c_clear, c_store, c_nrow, c_nfilt, c_done, c_ld;
    int first_clear, first_store, first_nrow, first_nfilt, first_done, last_ld, busy_at_done;
    int put_cyc [0:63];

    function automatic int outs_vec();
        return int'({ld_stride, ld_filterSize, put_data, put_filter, clear_sum,
                     store_buffer, next_row, next_filter, busy, done});
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic job_setup(input int rows, input int filts, input int wl, input int wpr);
        num_rows     = 8'(rows);
        num_filters  = 8'(filts);
        win_len      = wl;
        wins_per_row = wpr;
        beat_idx = 0; win_idx = 0; cyc = 0;
        c_put = 0; c_clear = 0; c_store = 0; c_nrow = 0; c_nfilt = 0; c_done = 0; c_ld = 0;
        first_clear = -1; first_store = -1; first_nrow = -1; first_nfilt = -1;
        first_done = -1; last_ld = -1; busy_at_done = -1;
        for (int i = 0; i < 64; i++) put_cyc[i] = -1;
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, advance to next negedge.
    task automatic cycle(input logic s, input logic ad, input logic af);
        start      = s;
        av_data    = ad;
        av_filter  = af;
        co_filter  = (beat_idx == win_len - 1);
        end_of_row = (win_idx == wins_per_row - 1);
        #1;
        check("inv_put_eq", int'(put_filter), int'(put_data));
        check("inv_clear_put", int'(clear_sum && !put_data), 0);
        check("inv_onehot", int'($countones({store_buffer, next_row, done}) > 1), 0);
        if (put_data) begin
            if (c_put < 64) put_cyc[c_put] = cyc;
            c_put++;
            if (co_filter) begin
                beat_idx = 0;
                if (end_of_row) win_idx = 0; else win_idx++;
            end else begin
                beat_idx++;
            end
        end
        if (clear_sum)    begin c_clear++; if (first_clear < 0) first_clear = cyc; end
        if (store_buffer) begin c_store++; if (first_store < 0) first_store = cyc; end
        if (next_row)     begin c_nrow++;  if (first_nrow  < 0) first_nrow  = cyc; end
        if (next_filter)  begin c_nfilt++; if (first_nfilt < 0) first_nfilt = cyc; end
        if (done)         begin c_done++;  if (first_done  < 0) begin first_done = cyc; busy_at_done = int'(busy); end end
        if (ld_stride && ld_filterSize) begin c_ld++; last_ld = cyc; end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("reset_outputs", outs_vec(), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_after_reset", outs_vec(), 0);
        @(negedge clk);

        // ---------------- T2: 1 row, 1 filter, window 3 ----------------
        job_setup(1, 1, 3, 1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 14; k++) cycle(1'b0, 1'b1, 1'b1);
        check("t2_ld_cycle", last_ld, 1);
        check("t2_puts", c_put, 3);
        check("t2_put0", put_cyc[0], 2);
        check("t2_put2", put_cyc[2], 4);
        check("t2_clear_cyc", first_clear, 2);
        check("t2_clear_cnt", c_clear, 1);
        check("t2_store_cyc", first_store, 5);
        check("t2_nrow_cyc", first_nrow, 6);
        check("t2_nfilt_cyc", first_nfilt, 6);
        check("t2_done_cyc", first_done, 10);
        check("t2_done_cnt", c_done, 1);
        check("t2_busy_at_done", busy_at_done, 1);
        check("t2_idle_busy", int'(busy), 0);

        // ---------------- T3: stall av_data in cycles 3-4 ----------------
        job_setup(1, 1, 3, 1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 16; k++) cycle(1'b0, (k == 3 || k == 4) ? 1'b0 : 1'b1, 1'b1);
        check("t3_puts", c_put, 3);
        check("t3_put0", put_cyc[0], 2);
        check("t3_put1", put_cyc[1], 5);
        check("t3_put2", put_cyc[2], 6);
        check("t3_clear_cyc", first_clear, 2);
        check("t3_store_cyc", first_store, 7);
        check("t3_done_cyc", first_done, 12);

        // ---------------- T4: 2 rows, 2 filters, 2 windows/row, window 2 ----------------
        job_setup(2, 2, 2, 2);
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 40; k++) cycle(1'b0, 1'b1, 1'b1);
        check("t4_puts", c_put, 16);
        check("t4_stores", c_store, 8);
        check("t4_clears", c_clear, 8);
        check("t4_nrows", c_nrow, 4);
        check("t4_nfilts", c_nfilt, 2);
        check("t4_dones", c_done, 1);
        check("t4_done_cyc", first_done, 33);

        // ---------------- T5: zero filters ----------------
        job_setup(3, 0, 2, 1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 6; k++) cycle(1'b0, 1'b1, 1'b1);
        check("t5_ld_cycle", last_ld, 1);
        check("t5_puts", c_put, 0);
        check("t5_stores", c_store, 0);
        check("t5_done_cyc", first_done, 2);
        check("t5_dones", c_done, 1);

        // ---------------- T1: reset mid-MAC ----------------
        job_setup(1, 1, 4, 1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 3; k++) cycle(1'b0, 1'b1, 1'b1);
        // now in cycle 3 (MAC), operands available
        av_data = 1'b1; av_filter = 1'b1;
        #1;
        check("t1_pre_put", int'(put_data), 1);
        rst = 1'b0;
        #1;
        check("t1_outs_in_reset", outs_vec(), 0);
        check("t1_busy_in_reset", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        job_setup(1, 1, 4, 1);
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, 1'b1);
        check("t1_no_puts", c_put, 0);
        check("t1_no_done", c_done, 0);
        check("t1_idle", int'(busy), 0);

        // ---------------- T6: start held high ----------------
        job_setup(1, 1, 1, 1);
        for (int k = 0; k < 11; k++) cycle(1'b1, 1'b1, 1'b1);
        check("t6_clear_cyc", first_clear, 2);
        check("t6_store_cyc", first_store, 3);
        check("t6_done_cyc", first_done, 8);
        check("t6_dones", c_done, 1);
        check("t6_ld_cnt", c_ld, 2);
        check("t6_second_cfg", last_ld, 10);

        rst = 1'b0;
        #1;
        check("final_reset", outs_vec(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
